// File: rtl/mesh_pkg.sv
// Shared definitions for the sorting-mesh read agent:
// packet field layout, FSM encoding and packet builder.
package mesh_pkg;

    localparam int MESH_ADDR_W = 4;
    localparam int MESH_DATA_W = 4;
    localparam int PKT_W       = MESH_ADDR_W + MESH_DATA_W + 1;

    localparam int PKT_VALID  = MESH_ADDR_W + MESH_DATA_W;
    localparam int PKT_KEY_HI = MESH_ADDR_W + MESH_DATA_W - 1;
    localparam int PKT_KEY_LO = MESH_DATA_W;
    localparam int PKT_PAY_HI = MESH_DATA_W - 1;
    localparam int PKT_PAY_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOOKUP,
        S_RSP,
        S_DONE
    } state_t;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic                   valid,
        input logic [MESH_ADDR_W-1:0] key,
        input logic [MESH_DATA_W-1:0] pay
    );
        return {valid, key, pay};
    endfunction

endpackage

// File: rtl/mesh_phase_timer.sv
// Phase counter shared by the request and response sort phases;
// done marks the last cycle of a SORT_CYCLES-long phase.
module mesh_phase_timer #(
    parameter int SORT_CYCLES = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(SORT_CYCLES + 1);

    logic [CW-1:0] count;

    assign done = (count == CW'(SORT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mesh_read_node.sv
// Per-node read agent: request sort to the owner, owner replies,
// response sort back to the requester.
module mesh_read_node
    import mesh_pkg::*;
#(
    parameter int N           = 16,
    parameter int ADDR_WIDTH  = MESH_ADDR_W,
    parameter int DATA_WIDTH  = MESH_DATA_W,
    parameter int SORT_CYCLES = 21,
    parameter int NODE_ID     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          mem_word,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] mesh_in,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] mesh_out,
    output logic                           mesh_load,
    output logic                           busy,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           err
);

    localparam logic [ADDR_WIDTH-1:0] MY_KEY = ADDR_WIDTH'(NODE_ID % N);
    localparam logic [DATA_WIDTH-1:0] MY_PAY = DATA_WIDTH'(NODE_ID % N);

    state_t state, state_nx;
    logic   t_clear, t_en, t_done;
    logic   hit;

    logic [ADDR_WIDTH-1:0] in_key;
    logic [DATA_WIDTH-1:0] in_pay;

    assign in_key = mesh_in[PKT_KEY_HI:PKT_KEY_LO];
    assign in_pay = mesh_in[PKT_PAY_HI:PKT_PAY_LO];
    assign hit    = mesh_in[PKT_VALID] && (in_key == MY_KEY);

    mesh_phase_timer #(
        .SORT_CYCLES(SORT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(t_clear),
        .en   (t_en),
        .done (t_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_REQ;
            S_REQ:    if (t_done) state_nx = S_LOOKUP;
            S_LOOKUP: state_nx = S_RSP;
            S_RSP:    if (t_done) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // The timer restarts on entry to each sort phase
    always_comb begin
        t_clear = 1'b0;
        t_en    = 1'b0;
        unique case (state)
            S_IDLE:   t_clear = start;
            S_REQ:    t_en    = 1'b1;
            S_LOOKUP: t_clear = 1'b1;
            S_RSP:    t_en    = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mesh_out  <= '0;
            mesh_load <= 1'b0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
        end else begin
            mesh_load <= 1'b0;
            rd_valid  <= 1'b0;
            if (rd_valid) busy <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mesh_out  <= make_pkt(1'b1, req_addr, MY_PAY);
                        mesh_load <= 1'b1;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    mesh_load <= 1'b1;
                    if (hit) begin
                        mesh_out <= make_pkt(1'b1, in_pay[ADDR_WIDTH-1:0],
                                             mem_word);
                    end else begin
                        mesh_out <= '0;
                        err      <= 1'b1;
                    end
                end
                S_DONE: begin
                    rd_data  <= in_pay;
                    rd_valid <= 1'b1;
                    if (!hit) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_read_node.sv
// Sixteen read agents around a behavioural sorter that places
// packets by key SORT_CYCLES cycles after each load strobe.
module tb_mesh_read_node;

    localparam int S = 21;
    localparam int LAT = 2 * S + 2;

    typedef logic [8:0] pkt_arr_t [16];

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] start;
    logic [3:0]  req_addr [16];
    logic [3:0]  mem [16];
    logic [8:0]  mesh_in [16];
    logic [8:0]  mesh_out [16];
    logic [15:0] mesh_load, busy, rd_valid, err;
    logic [3:0]  rd_data [16];

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int e0, first_at, prev_at;
    int pulses [16];
    logic [15:0] busy_first, busy_done, busy_after;

    pkt_arr_t sreg;
    int       scnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 16; g++) begin : g_node
        assign mesh_in[g] = sreg[g];
        mesh_read_node #(
            .N(16), .ADDR_WIDTH(4), .DATA_WIDTH(4),
            .SORT_CYCLES(S), .NODE_ID(g)
        ) u_node (
            .clk(clk), .rst(rst), .start(start[g]),
            .req_addr(req_addr[g]), .mem_word(mem[g]),
            .mesh_in(mesh_in[g]), .mesh_out(mesh_out[g]),
            .mesh_load(mesh_load[g]), .busy(busy[g]),
            .rd_valid(rd_valid[g]), .rd_data(rd_data[g]),
            .err(err[g])
        );
    end

    function automatic pkt_arr_t place(input pkt_arr_t p);
        pkt_arr_t t;
        for (int i = 0; i < 16; i++) t[i] = '0;
        for (int i = 0; i < 16; i++)
            if (p[i][8]) t[p[i][7:4]] = p[i];
        return t;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) sreg[i] <= '0;
            scnt <= 0;
        end else if (mesh_load != 16'h0) begin
            for (int i = 0; i < 16; i++) sreg[i] <= mesh_out[i];
            scnt <= S - 1;
        end else if (scnt > 0) begin
            scnt <= scnt - 1;
            if (scnt == 1) sreg <= place(sreg);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] data_vec();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = rd_data[i];
        return v;
    endfunction

    function automatic logic [63:0] exp_shift(input int s);
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = ~4'((i + s) % 16);
        return v;
    endfunction

    function automatic logic [15:0] pulse_ok();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = (pulses[i] == 1);
        return v;
    endfunction

    task automatic set_req(input int s);
        for (int i = 0; i < 16; i++) req_addr[i] = 4'((i + s) % 16);
    endtask

    task automatic set_mem_inv();
        for (int a = 0; a < 16; a++) mem[a] = ~4'(a);
    endtask

    task automatic kick();
        @(negedge clk);
        start = 16'hFFFF;
        @(negedge clk);
        start = 16'h0;
        e0 = cyc;
    endtask

    task automatic run_obs(input int poke);
        first_at = -1;
        for (int i = 0; i < 16; i++) pulses[i] = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            start = (poke > 0 && cyc == e0 + poke - 1) ? 16'hFFFF : 16'h0;
            for (int i = 0; i < 16; i++) pulses[i] += int'(rd_valid[i]);
            if (rd_valid[0] && first_at < 0) first_at = cyc;
            if (cyc == e0 + 1)       busy_first = busy;
            if (cyc == e0 + LAT)     busy_done = busy;
            if (cyc == e0 + LAT + 1) busy_after = busy;
        end
    endtask

    task automatic check_std(input string tag, input logic [63:0] exp_d);
        check({tag, "_lat"}, 64'(first_at - e0), 64'(LAT));
        check({tag, "_pulses"}, 64'(pulse_ok()), 64'hFFFF);
        check({tag, "_busy"}, {busy_first, busy_done, busy_after},
              {16'hFFFF, 16'hFFFF, 16'h0});
        check({tag, "_data"}, data_vec(), exp_d);
        check({tag, "_err"}, 64'(err), 64'h0);
    endtask

    task automatic check_reset_outs(input string tag);
        logic [63:0] pk;
        pk = '0;
        for (int i = 0; i < 16; i++) begin
            pk[i]      = |mesh_out[i];
            pk[16 + i] = |rd_data[i];
        end
        check({tag, "_ctl"}, 64'({mesh_load, busy, rd_valid, err}), 64'h0);
        check({tag, "_pkt"}, pk, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        start = 16'h0;
        set_req(0);
        set_mem_inv();
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        // 1: shifted permutation, mem[a] = ~a
        set_req(5);
        kick();
        run_obs(0);
        check_std("shift5", exp_shift(5));

        // 2: identity read, all-ones memory
        set_req(0);
        for (int a = 0; a < 16; a++) mem[a] = 4'hF;
        kick();
        run_obs(0);
        check_std("ident", 64'hFFFF_FFFF_FFFF_FFFF);

        // 3: start pulsed again while busy
        set_req(5);
        set_mem_inv();
        kick();
        run_obs(5);
        check_std("busy_start", exp_shift(5));

        // 4: nodes 0 and 1 both read address 3
        set_req(0);
        req_addr[0] = 4'd3;
        req_addr[1] = 4'd3;
        kick();
        run_obs(0);
        check("dup_lat", 64'(first_at - e0), 64'(LAT));
        check("dup_pulses", 64'(pulse_ok()), 64'hFFFF);
        check("dup_err", 64'(err), 64'h0003);
        check("dup_busy_after", 64'(busy_after), 64'h0);

        // 5: reset in the middle of the request phase
        set_req(5);
        kick();
        while (cyc < e0 + 10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        @(negedge clk);
        rst = 1'b0;
        kick();
        run_obs(0);
        check_std("after_rst", exp_shift(5));

        // 6: back-to-back, second start in the cycle after DONE
        set_req(0);
        kick();
        for (int k = 0; k < LAT && cyc < e0 + LAT; k++) @(negedge clk);
        check("b2b_first_rv", 64'(rd_valid), 64'hFFFF);
        check("b2b_first_data", data_vec(), exp_shift(0));
        prev_at = cyc;
        set_req(5);
        start = 16'hFFFF;
        @(negedge clk);
        start = 16'h0;
        e0 = cyc;
        run_obs(0);
        check("b2b_gap", 64'(first_at - prev_at), 64'(2 * S + 3));
        check_std("b2b_second", exp_shift(5));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
